// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel alarm controller.
// Holds the event FSM encoding, width helpers and the trigger priority encoder.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

    // Lowest set bit wins so channel 0 has the highest priority.
    function automatic int lowest_set(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/alarm_ring_ctrl_sync_pipe.sv
// Plain register chain used to bring bundles into the clk domain.
// The whole bundle moves together so control and data stay aligned.
module sync_pipe #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Multi-channel alarm store with edge-triggered match and a
// ring/snooze event machine timed by an external tick.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_ALM      = 4,
    parameter int SYNC_STAGES  = 3,
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 5,
    parameter int MAX_SNOOZE   = 3,
    localparam int ID_W        = id_width(NUM_ALM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [ID_W-1:0]    load_sel,
    input  logic [DATA_W-1:0]  data_in_load,
    input  logic [DATA_W-1:0]  data_in_cmp,
    input  logic [NUM_ALM-1:0] alm_en,
    input  logic               tick,
    input  logic               stop,
    input  logic               snooze,
    input  logic [ID_W-1:0]    rd_sel,
    output logic [DATA_W-1:0]  data_ring,
    output logic               ring,
    output logic [ID_W-1:0]    ring_id,
    output logic               missed
);

    localparam int CNT_MAX = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int SNZ_W   = cnt_width(MAX_SNOOZE);
    localparam int LD_W    = 1 + ID_W + DATA_W;

    logic [LD_W-1:0]    ld_bus;
    logic               ld;
    logic [ID_W-1:0]    ld_sel;
    logic [DATA_W-1:0]  ld_data;
    logic [DATA_W-1:0]  cmp_s;
    logic [DATA_W-1:0]  alarm [NUM_ALM];
    logic [DATA_W-1:0]  rd_val;
    logic [NUM_ALM-1:0] match, match_d, trig, losers;
    logic [ID_W-1:0]    win;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SNZ_W-1:0]   snz_cnt, snz_n;
    logic [ID_W-1:0]    id_n;
    logic               missed_n;

    sync_pipe #(.WIDTH(LD_W), .STAGES(SYNC_STAGES)) u_ld_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({load, load_sel, data_in_load}),
        .q     (ld_bus)
    );

    sync_pipe #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (data_in_cmp),
        .q     (cmp_s)
    );

    assign {ld, ld_sel, ld_data} = ld_bus;

    // Out-of-range selects match no channel, so they write nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALM; i++) alarm[i] <= '0;
        end else if (ld) begin
            for (int i = 0; i < NUM_ALM; i++) begin
                if (ld_sel == ID_W'(i)) alarm[i] <= ld_data;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_ALM; i++) begin
            if (rd_sel == ID_W'(i)) rd_val = alarm[i];
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALM; i++) begin
            match[i] = alm_en[i] && (alarm[i] == cmp_s);
        end
    end

    assign trig = match & ~match_d;
    assign win  = ID_W'(lowest_set(32'(trig)));

    always_comb begin
        losers = trig;
        for (int i = 0; i < NUM_ALM; i++) begin
            if (win == ID_W'(i)) losers[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            snz_cnt   <= '0;
            ring_id   <= '0;
            missed    <= 1'b0;
            ring      <= 1'b0;
            data_ring <= '0;
            match_d   <= '1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            snz_cnt   <= snz_n;
            ring_id   <= id_n;
            missed    <= missed_n;
            ring      <= (state == RINGING);
            data_ring <= rd_val;
            match_d   <= match;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        snz_n    = snz_cnt;
        id_n     = ring_id;
        missed_n = missed;
        if (stop) missed_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (|trig) begin
                    state_n = RINGING;
                    id_n    = win;
                    cnt_n   = CNT_W'(RING_TICKS);
                    snz_n   = '0;
                    if (|losers) missed_n = 1'b1;
                end
            end
            RINGING: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (snooze) begin
                    if (snz_cnt < SNZ_W'(MAX_SNOOZE)) begin
                        state_n = SNOOZED;
                        cnt_n   = CNT_W'(SNOOZE_TICKS);
                        snz_n   = snz_cnt + SNZ_W'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end else if (tick) begin
                    if (cnt == CNT_W'(1)) state_n = IDLE;
                    else cnt_n = cnt - CNT_W'(1);
                end
            end
            SNOOZED: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (cnt == CNT_W'(1)) begin
                        state_n = RINGING;
                        cnt_n   = CNT_W'(RING_TICKS);
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // A trigger landing on a busy controller is reported, never queued.
        if (state != IDLE && |trig) missed_n = 1'b1;
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with short tick counts.
// Five channels so that a 3-bit select can address a missing channel.
module tb_alarm_ring_ctrl;

    localparam int DW   = 16;
    localparam int NA   = 5;
    localparam int SS   = 3;
    localparam int RT   = 3;
    localparam int ST   = 5;
    localparam int MS   = 1;
    localparam int IW   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [IW-1:0] load_sel;
    logic [DW-1:0] data_in_load;
    logic [DW-1:0] data_in_cmp;
    logic [NA-1:0] alm_en;
    logic          tick;
    logic          stop;
    logic          snooze;
    logic [IW-1:0] rd_sel;
    logic [DW-1:0] data_ring;
    logic          ring;
    logic [IW-1:0] ring_id;
    logic          missed;

    int n_chk  = 0;
    int n_fail = 0;

    alarm_ring_ctrl #(
        .DATA_W       (DW),
        .NUM_ALM      (NA),
        .SYNC_STAGES  (SS),
        .RING_TICKS   (RT),
        .SNOOZE_TICKS (ST),
        .MAX_SNOOZE   (MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_sel     (load_sel),
        .data_in_load (data_in_load),
        .data_in_cmp  (data_in_cmp),
        .alm_en       (alm_en),
        .tick         (tick),
        .stop         (stop),
        .snooze       (snooze),
        .rd_sel       (rd_sel),
        .data_ring    (data_ring),
        .ring         (ring),
        .ring_id      (ring_id),
        .missed       (missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_ch(input logic [IW-1:0] ch, input logic [DW-1:0] val);
        load = 1'b1;
        load_sel = ch;
        data_in_load = val;
        step(1);
        load = 1'b0;
        step(SS + 1);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
    endtask

    // Moves cmp away then back so the match gets a fresh rising edge.
    task automatic retrigger(input logic [DW-1:0] val);
        data_in_cmp = '0;
        step(SS + 1);
        data_in_cmp = val;
        step(SS + 2);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        load_sel = '0;
        data_in_load = '0;
        data_in_cmp = '0;
        alm_en = '0;
        tick = 1'b0;
        stop = 1'b0;
        snooze = 1'b0;
        rd_sel = '0;
        #12;
        rst_n = 1'b1;
        step(1);
        check("rst_ring", 32'(ring), 0);
        check("rst_id", 32'(ring_id), 0);
        check("rst_missed", 32'(missed), 0);
        check("rst_data_ring", 32'(data_ring), 0);

        load_ch(3'd1, 16'h0730);
        alm_en = 5'b00010;
        rd_sel = 3'd1;
        step(1);
        check("rd_ch1", 32'(data_ring), 32'h0730);
        data_in_cmp = 16'h0730;
        step(SS + 1);
        check("lat_ring_early", 32'(ring), 0);
        step(1);
        check("lat_ring", 32'(ring), 1);
        check("lat_id", 32'(ring_id), 1);

        pulse_tick();
        pulse_tick();
        check("tick2_ring", 32'(ring), 1);
        pulse_tick();
        check("tick3_ring", 32'(ring), 0);
        check("tick3_missed", 32'(missed), 0);
        step(10);
        check("held_no_retrig", 32'(ring), 0);

        retrigger(16'h0730);
        check("snz_ring_on", 32'(ring), 1);
        snooze = 1'b1;
        tick = 1'b1;
        step(1);
        snooze = 1'b0;
        tick = 1'b0;
        check("snz_tick_state", 32'(dut.state), 2);
        check("snz_tick_cnt", 32'(dut.cnt), ST);
        step(1);
        check("snz_ring_off", 32'(ring), 0);
        for (int i = 0; i < ST - 1; i++) pulse_tick();
        check("snz_wait_ring", 32'(ring), 0);
        pulse_tick();
        check("rering", 32'(ring), 1);
        check("rering_cnt", 32'(dut.cnt), RT);
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        step(1);
        check("snz_limit_ring", 32'(ring), 0);
        check("snz_limit_state", 32'(dut.state), 0);

        alm_en = 5'b00101;
        load_ch(3'd0, 16'h1200);
        load_ch(3'd2, 16'h1200);
        data_in_cmp = 16'h1200;
        step(SS + 2);
        check("multi_ring", 32'(ring), 1);
        check("multi_id", 32'(ring_id), 0);
        check("multi_missed", 32'(missed), 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        check("stop_ring", 32'(ring), 0);
        check("stop_missed", 32'(missed), 0);
        step(8);
        check("stop_no_retrig", 32'(ring), 0);

        retrigger(16'h1200);
        check("ss_ring_on", 32'(ring), 1);
        stop = 1'b1;
        snooze = 1'b1;
        step(1);
        stop = 1'b0;
        snooze = 1'b0;
        check("ss_state", 32'(dut.state), 0);
        check("ss_missed", 32'(missed), 0);

        retrigger(16'h1200);
        rd_sel = 3'd2;
        step(1);
        check("pre_rst_ring", 32'(ring), 1);
        check("pre_rst_rd", 32'(data_ring), 32'h1200);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_ring", 32'(ring), 0);
        check("async_data_ring", 32'(data_ring), 0);
        check("async_missed", 32'(missed), 0);
        #2;
        rst_n = 1'b1;
        step(8);
        check("post_rst_no_trig", 32'(ring), 0);

        alm_en = '0;
        load_ch(3'd5, 16'hBEEF);
        for (int i = 0; i < 6; i++) begin
            rd_sel = IW'(i);
            step(1);
            check($sformatf("oob_rd%0d", i), 32'(data_ring), 0);
        end
        load_ch(3'd4, 16'h2359);
        rd_sel = 3'd4;
        step(1);
        check("rd_ch4", 32'(data_ring), 32'h2359);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
